fetch_controller: RTL and testbench

Instruction-fetch sequencer that drives the control side of the program counter (`inc`, `ld`, `d`) and consumes its output `q`. It fetches one instruction word per PC value over a req/ack memory handshake, presents it downstream on a valid/ready port, and applies branch redirects by loading the PC. It sits between `program_counter`, instruction memory and the decode stage of the datapath.

---
 rtl/fetch_controller.sv | 160 ++++++++++++++++
 tb/tb_fetch_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer between program_counter, instruction memory and decode.
// Define FETCH_TIMEOUT_EN to add the ack-wait timeout counter and the sticky FAULT state.
module fetch_controller #(
   parameter int INSTR_W        = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [INSTR_W-1:0] pc_q,
   output logic               pc_inc,
   output logic               pc_ld,
   output logic [INSTR_W-1:0] pc_d,
   input  logic               redirect,
   input  logic [INSTR_W-1:0] redirect_addr,
   output logic               mem_req,
   output logic [INSTR_W-1:0] mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [INSTR_W-1:0] instr_pc,
   output logic               fetch_fault
);

`ifdef FETCH_TIMEOUT_EN
   typedef enum logic [1:0] {FETCH, ISSUE, DRAIN, FAULT} state_t;
`else
   typedef enum logic [1:0] {FETCH, ISSUE, DRAIN} state_t;
`endif

   state_t             state;
   state_t             next_state;
   logic [INSTR_W-1:0] req_addr;
   logic [INSTR_W-1:0] instr_q;
   logic [INSTR_W-1:0] instr_pc_q;
   logic               valid_q;
   logic               capture;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0]   wait_cnt;
   logic               fault_q;
   logic               timeout_hit;

   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   // Next-state and PC/memory control; redirect outranks ack and ready in every active state.
   always_comb begin
      next_state = state;
      pc_inc     = 1'b0;
      pc_ld      = 1'b0;
      pc_d       = '0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      capture    = 1'b0;
      if (!clr) begin
         case (state)
            FETCH: begin
               mem_req  = 1'b1;
               mem_addr = pc_q;
               if (redirect) begin
                  pc_ld      = 1'b1;
                  pc_d       = redirect_addr;
                  next_state = mem_ack ? FETCH : DRAIN;
               end else if (mem_ack) begin
                  pc_inc     = 1'b1;
                  capture    = 1'b1;
                  next_state = ISSUE;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (timeout_hit) begin
                  next_state = FAULT;
               end
`endif
            end
            ISSUE: begin
               if (redirect) begin
                  pc_ld      = 1'b1;
                  pc_d       = redirect_addr;
                  next_state = FETCH;
               end else if (instr_ready) begin
                  next_state = FETCH;
               end
            end
            DRAIN: begin
               // Keep presenting the abandoned address until its ack arrives and is dropped.
               mem_req  = 1'b1;
               mem_addr = req_addr;
               if (redirect) begin
                  pc_ld      = 1'b1;
                  pc_d       = redirect_addr;
                  next_state = DRAIN;
               end else if (mem_ack) begin
                  next_state = FETCH;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (timeout_hit) begin
                  next_state = FAULT;
               end
`endif
            end
            default: begin
               next_state = state;
            end
         endcase
      end
   end

   // State register plus the held instruction word and its PC.
   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= FETCH;
         req_addr   <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         state   <= next_state;
         valid_q <= (next_state == ISSUE);
         if (state == FETCH) begin
            req_addr <= pc_q;
         end
         if (capture) begin
            instr_q    <= mem_rdata;
            instr_pc_q <= pc_q;
         end
      end
   end

`ifdef FETCH_TIMEOUT_EN
   // Wait counter restarts whenever the wait is broken by an ack, a redirect or a state change.
   always_ff @(posedge clk) begin
      if (clr) begin
         wait_cnt <= '0;
         fault_q  <= 1'b0;
      end else begin
         if (next_state == FAULT) begin
            fault_q <= 1'b1;
         end
         if ((next_state != state) || mem_ack || redirect) begin
            wait_cnt <= '0;
         end else if ((state == FETCH) || (state == DRAIN)) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   assign fetch_fault = fault_q & ~clr;
`else
   assign fetch_fault = 1'b0;
`endif

   assign instr_valid = valid_q & ~clr;
   assign instr       = clr ? '0 : instr_q;
   assign instr_pc    = clr ? '0 : instr_pc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: table-driven cycle checks of fetch_controller against a small program_counter model.
// Build with FETCH_TIMEOUT_EN defined to also exercise the timeout/FAULT sequence.
module tb_fetch_controller;
   localparam int W = 32;

   logic         clk;
   logic         clr;
   logic [W-1:0] pc_q;
   logic         pc_inc;
   logic         pc_ld;
   logic [W-1:0] pc_d;
   logic         redirect;
   logic [W-1:0] redirect_addr;
   logic         mem_req;
   logic [W-1:0] mem_addr;
   logic         mem_ack;
   logic [W-1:0] mem_rdata;
   logic         instr_valid;
   logic         instr_ready;
   logic [W-1:0] instr;
   logic [W-1:0] instr_pc;
   logic         fetch_fault;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         clr;
      logic         rd;
      logic [W-1:0] rd_addr;
      logic         ack;
      logic [W-1:0] rdata;
      logic         rdy;
      logic         e_inc;
      logic         e_ld;
      logic [W-1:0] e_d;
      logic         e_req;
      logic [W-1:0] e_addr;
      logic         e_valid;
      logic [W-1:0] e_instr;
      logic [W-1:0] e_ipc;
   } vec_t;

   vec_t vq[$];

   localparam logic [W-1:0] A0   = 32'h1111_0000;
   localparam logic [W-1:0] A1   = 32'h2222_0004;
   localparam logic [W-1:0] A2   = 32'h3333_0008;
   localparam logic [W-1:0] A3   = 32'h4444_000C;
   localparam logic [W-1:0] A4   = 32'h5555_0100;
   localparam logic [W-1:0] A5   = 32'h6666_0200;
   localparam logic [W-1:0] A6   = 32'h7777_0300;
   localparam logic [W-1:0] JUNK = 32'hDEAD_BEEF;

   fetch_controller #(.INSTR_W(W), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .clr(clr), .pc_q(pc_q), .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_d(pc_d),
      .redirect(redirect), .redirect_addr(redirect_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
      .fetch_fault(fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for program_counter: cleared by clr, load beats increment, steps by one word.
   always @(posedge clk) begin
      if (clr) pc_q <= '0;
      else if (pc_ld) pc_q <= pc_d;
      else if (pc_inc) pc_q <= pc_q + 32'd4;
   end

   always @(negedge clk) begin
      checks++;
      if (pc_inc && pc_ld) begin
         errors++;
         $display("[TB] FAIL inc_ld_exclusive at %0t: pc_inc=%b pc_ld=%b, required not both 1", $time, pc_inc, pc_ld);
      end
   end

   function automatic vec_t mk(input logic c, input logic rd, input logic [W-1:0] ra, input logic ack,
                               input logic [W-1:0] rdata, input logic rdy, input logic e_inc,
                               input logic e_ld, input logic [W-1:0] e_d, input logic e_req,
                               input logic [W-1:0] e_addr, input logic e_valid,
                               input logic [W-1:0] e_instr, input logic [W-1:0] e_ipc);
      vec_t v;
      v.clr = c; v.rd = rd; v.rd_addr = ra; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
      v.e_inc = e_inc; v.e_ld = e_ld; v.e_d = e_d; v.e_req = e_req; v.e_addr = e_addr;
      v.e_valid = e_valid; v.e_instr = e_instr; v.e_ipc = e_ipc;
      return v;
   endfunction

   task automatic check1(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(posedge clk);
      #1;
      clr           = v.clr;
      redirect      = v.rd;
      redirect_addr = v.rd_addr;
      mem_ack       = v.ack;
      mem_rdata     = v.rdata;
      instr_ready   = v.rdy;
   endtask

   task automatic checkOutput(input vec_t v, input int row);
      check1($sformatf("row%0d pc_inc", row), W'(pc_inc), W'(v.e_inc));
      check1($sformatf("row%0d pc_ld", row), W'(pc_ld), W'(v.e_ld));
      check1($sformatf("row%0d pc_d", row), pc_d, v.e_d);
      check1($sformatf("row%0d mem_req", row), W'(mem_req), W'(v.e_req));
      if (v.e_req || v.clr) check1($sformatf("row%0d mem_addr", row), mem_addr, v.e_addr);
      check1($sformatf("row%0d instr_valid", row), W'(instr_valid), W'(v.e_valid));
      check1($sformatf("row%0d instr", row), instr, v.e_instr);
      check1($sformatf("row%0d instr_pc", row), instr_pc, v.e_ipc);
      check1($sformatf("row%0d fetch_fault", row), W'(fetch_fault), '0);
   endtask

   initial begin
      logic [W-1:0] exp_pc;
      logic         got;

      clr = 1'b1; redirect = 1'b0; redirect_addr = '0; mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b1;

      // Columns: clr rd rd_addr ack rdata rdy | inc ld d req addr valid instr instr_pc
      vq.push_back(mk(1,0,0,    0,0,   1, 0,0,0,    0,0,    0,0, 0));
      vq.push_back(mk(1,0,0,    0,0,   1, 0,0,0,    0,0,    0,0, 0));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    1,0,    0,0, 0));
      vq.push_back(mk(0,0,0,    1,A0,  1, 1,0,0,    1,0,    0,0, 0));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    0,0,    1,A0,0));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    1,4,    0,A0,0));
      vq.push_back(mk(0,0,0,    1,A1,  1, 1,0,0,    1,4,    0,A0,0));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    0,0,    1,A1,4));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    1,8,    0,A1,4));
      vq.push_back(mk(0,0,0,    1,A2,  1, 1,0,0,    1,8,    0,A1,4));
      vq.push_back(mk(0,0,0,    0,0,   0, 0,0,0,    0,0,    1,A2,8));
      vq.push_back(mk(0,0,0,    0,0,   0, 0,0,0,    0,0,    1,A2,8));
      vq.push_back(mk(0,0,0,    1,JUNK,0, 0,0,0,    0,0,    1,A2,8));
      vq.push_back(mk(0,0,0,    0,0,   0, 0,0,0,    0,0,    1,A2,8));
      vq.push_back(mk(0,0,0,    0,0,   0, 0,0,0,    0,0,    1,A2,8));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    0,0,    1,A2,8));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    1,12,   0,A2,8));
      vq.push_back(mk(0,0,0,    1,A3,  1, 1,0,0,    1,12,   0,A2,8));
      vq.push_back(mk(0,1,'h100,0,0,   0, 0,1,'h100,0,0,    1,A3,12));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    1,'h100,0,A3,12));
      vq.push_back(mk(0,0,0,    1,A4,  1, 1,0,0,    1,'h100,0,A3,12));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    0,0,    1,A4,'h100));
      vq.push_back(mk(0,1,'h200,0,0,   1, 0,1,'h200,1,'h104,0,A4,'h100));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    1,'h104,0,A4,'h100));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    1,'h104,0,A4,'h100));
      vq.push_back(mk(0,0,0,    1,JUNK,1, 0,0,0,    1,'h104,0,A4,'h100));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    1,'h200,0,A4,'h100));
      vq.push_back(mk(0,1,'h300,1,A5,  1, 0,1,'h300,1,'h200,0,A4,'h100));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    1,'h300,0,A4,'h100));
      vq.push_back(mk(0,0,0,    1,A6,  1, 1,0,0,    1,'h300,0,A4,'h100));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    0,0,    1,A6,'h300));
      vq.push_back(mk(0,1,'h400,0,0,   1, 0,1,'h400,1,'h304,0,A6,'h300));
      vq.push_back(mk(0,1,'h500,0,0,   1, 0,1,'h500,1,'h304,0,A6,'h300));
      vq.push_back(mk(0,0,0,    1,JUNK,1, 0,0,0,    1,'h304,0,A6,'h300));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    1,'h500,0,A6,'h300));
      vq.push_back(mk(1,0,0,    1,A5,  1, 0,0,0,    0,0,    0,0, 0));
      vq.push_back(mk(0,0,0,    0,0,   1, 0,0,0,    1,0,    0,0, 0));

      $display("[TB] applying %0d table vectors", vq.size());
      for (int i = 0; i < vq.size(); i++) begin
         applyStimulus(vq[i]);
         @(negedge clk);
         checkOutput(vq[i], i);
      end

      // Sequential fetches with growing ack wait; each word must surface one cycle after its ack.
      exp_pc = '0;
      for (int k = 0; k < 4; k++) begin
         for (int w = 0; w < k; w++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            @(negedge clk);
            check1($sformatf("seq%0d wait mem_req", k), W'(mem_req), W'(1));
            check1($sformatf("seq%0d wait mem_addr", k), mem_addr, exp_pc);
            check1($sformatf("seq%0d wait pc_inc", k), W'(pc_inc), '0);
         end
         @(posedge clk); #1;
         mem_ack   = 1'b1;
         mem_rdata = 32'hC000_0000 + W'(k);
         @(negedge clk);
         check1($sformatf("seq%0d ack mem_addr", k), mem_addr, exp_pc);
         check1($sformatf("seq%0d ack pc_inc", k), W'(pc_inc), W'(1));
         got = 1'b0;
         for (int c = 0; c < 4 && !got; c++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            @(negedge clk);
            if (instr_valid) got = 1'b1;
         end
         check1($sformatf("seq%0d valid_seen", k), W'(got), W'(1));
         check1($sformatf("seq%0d instr", k), instr, 32'hC000_0000 + W'(k));
         check1($sformatf("seq%0d instr_pc", k), instr_pc, exp_pc);
         exp_pc = exp_pc + 32'd4;
      end

`ifdef FETCH_TIMEOUT_EN
      @(posedge clk); #1;
      clr = 1'b1; mem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clr = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         check1($sformatf("timeout c%0d mem_req", c), W'(mem_req), W'(1));
         check1($sformatf("timeout c%0d fetch_fault", c), W'(fetch_fault), '0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check1("timeout fetch_fault", W'(fetch_fault), W'(1));
      check1("timeout mem_req", W'(mem_req), '0);
      check1("timeout instr_valid", W'(instr_valid), '0);
      @(posedge clk); #1;
      redirect = 1'b1; redirect_addr = 32'h40;
      @(negedge clk);
      check1("fault redirect pc_ld", W'(pc_ld), '0);
      check1("fault sticky", W'(fetch_fault), W'(1));
      @(posedge clk); #1;
      redirect = 1'b0; clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      check1("post_fault mem_req", W'(mem_req), W'(1));
      check1("post_fault mem_addr", mem_addr, '0);
      check1("post_fault fetch_fault", W'(fetch_fault), '0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
